// File: rtl/sprite_line_filler_pkg.sv
// Shared constants, line-buffer entry layout and fill FSM states for the
// sprite line filler.
package vga_sprite_pkg;

  localparam int unsigned HACTIVE     = 640;
  localparam int unsigned MAX_OBJECTS = 20;
  localparam int unsigned SPRITE_W    = 16;
  localparam int unsigned SPRITE_H    = 16;
  localparam int unsigned COORD_W     = 12;

  localparam int unsigned X_W    = $clog2(HACTIVE);
  localparam int unsigned OBJ_W  = $clog2(MAX_OBJECTS);
  localparam int unsigned RAM_AW = X_W + 1;

  typedef struct packed {
    logic       valid;
    logic [4:0] obj_id;
    logic [5:0] sprite;
    logic [3:0] rel_x;
    logic [3:0] rel_y;
  } line_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    CHECK,
    DRAW,
    DONE
  } fill_state_t;

endpackage

// File: rtl/sprite_line_filler_if.sv
// Object-table read bus and pixel-stage query bus of the sprite line filler.
interface sprite_line_filler_if;
  import vga_sprite_pkg::*;

  logic [4:0]         obj_rd_idx;
  logic [COORD_W-1:0] obj_rd_x;
  logic [COORD_W-1:0] obj_rd_y;
  logic [5:0]         obj_rd_sprite;
  logic               obj_rd_active;

  logic [9:0]         disp_x;
  logic               disp_valid;
  logic [4:0]         disp_obj_id;
  logic [5:0]         disp_sprite;
  logic [3:0]         disp_rel_x;
  logic [3:0]         disp_rel_y;

  modport master (
    output obj_rd_idx,
    input  obj_rd_x, obj_rd_y, obj_rd_sprite, obj_rd_active,
    input  disp_x,
    output disp_valid, disp_obj_id, disp_sprite, disp_rel_x, disp_rel_y
  );

  modport slave (
    input  obj_rd_idx,
    output obj_rd_x, obj_rd_y, obj_rd_sprite, obj_rd_active,
    output disp_x,
    input  disp_valid, disp_obj_id, disp_sprite, disp_rel_x, disp_rel_y
  );
endinterface

// File: rtl/sprite_line_filler_ram.sv
// Ping-pong line buffer: one write port, one registered read port, address {bank, x}.
module line_bank_ram
  import vga_sprite_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] waddr,
  input  line_entry_t       wdata,
  input  logic [RAM_AW-1:0] raddr,
  output line_entry_t       rdata
);
  line_entry_t mem [2**RAM_AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/sprite_line_filler.sv
// Per-scanline sprite scan engine: builds one line into the back bank while the
// pixel stage reads the front bank by screen x.
module sprite_line_filler
  import vga_sprite_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        line_start,
  input  logic [9:0]                  line_y,
  sprite_line_filler_if.master        vga,
  output logic                        busy,
  output logic                        overrun
);
  fill_state_t        state, state_n;
  logic               rd_bank, wr_bank;
  logic [1:0]         filled;
  logic [9:0]         line_y_q;
  logic [X_W-1:0]     cnt;
  logic [OBJ_W-1:0]   obj_idx;
  logic [COORD_W-1:0] obj_x;
  logic [5:0]         obj_sprite;
  logic [3:0]         obj_rel_y;
  logic [COORD_W:0]   y_end, px, line_y_w;
  logic               hit, last_obj, valid_q;
  logic               we;
  logic [RAM_AW-1:0]  waddr;
  line_entry_t        wdata, rd_entry;

  assign wr_bank        = ~rd_bank;
  assign busy           = (state != IDLE);
  assign last_obj       = (obj_idx == '0);
  assign vga.obj_rd_idx = obj_idx;

  // One extra bit so coordinates near the top of the range cannot wrap.
  assign line_y_w = (COORD_W+1)'(line_y_q);
  assign y_end    = {1'b0, vga.obj_rd_y} + (COORD_W+1)'(SPRITE_H);
  assign px       = {1'b0, obj_x} + (COORD_W+1)'(cnt[3:0]);
  assign hit      = vga.obj_rd_active && (line_y_w >= {1'b0, vga.obj_rd_y}) && (line_y_w < y_end);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    we      = 1'b0;
    waddr   = {wr_bank, cnt};
    wdata   = '0;
    case (state)
      CLEAR: begin
        we = 1'b1;
        if (cnt == X_W'(HACTIVE-1)) state_n = FETCH;
      end
      FETCH: state_n = CHECK;
      CHECK: begin
        if (hit)           state_n = DRAW;
        else if (last_obj) state_n = DONE;
        else               state_n = FETCH;
      end
      DRAW: begin
        we    = (px < (COORD_W+1)'(HACTIVE));
        waddr = {wr_bank, px[X_W-1:0]};
        wdata = '{valid: 1'b1, obj_id: obj_idx, sprite: obj_sprite,
                  rel_x: cnt[3:0], rel_y: obj_rel_y};
        if (cnt == X_W'(SPRITE_W-1)) state_n = last_obj ? DONE : FETCH;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (line_start) state_n = CLEAR;
  end

  // line_start wins over completion so an overrun bank is never marked filled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_bank    <= 1'b0;
      filled     <= '0;
      line_y_q   <= '0;
      cnt        <= '0;
      obj_idx    <= '0;
      obj_x      <= '0;
      obj_sprite <= '0;
      obj_rel_y  <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= line_start && busy;
      if (line_start) begin
        rd_bank         <= ~rd_bank;
        filled[rd_bank] <= 1'b0;
        line_y_q        <= line_y;
        cnt             <= '0;
        obj_idx         <= OBJ_W'(MAX_OBJECTS-1);
      end else begin
        case (state)
          CLEAR: cnt <= (cnt == X_W'(HACTIVE-1)) ? '0 : cnt + 1'b1;
          CHECK: begin
            cnt        <= '0;
            obj_x      <= vga.obj_rd_x;
            obj_sprite <= vga.obj_rd_sprite;
            obj_rel_y  <= line_y_q[3:0] - vga.obj_rd_y[3:0];
            if (!hit && !last_obj) obj_idx <= obj_idx - 1'b1;
          end
          DRAW: begin
            cnt <= cnt + 1'b1;
            if (cnt == X_W'(SPRITE_W-1) && !last_obj) obj_idx <= obj_idx - 1'b1;
          end
          DONE:    filled[wr_bank] <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  line_bank_ram u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr ({rd_bank, vga.disp_x}),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= filled[rd_bank] && (vga.disp_x < X_W'(HACTIVE));
  end

  assign vga.disp_valid  = valid_q && rd_entry.valid;
  assign vga.disp_obj_id = vga.disp_valid ? rd_entry.obj_id : '0;
  assign vga.disp_sprite = vga.disp_valid ? rd_entry.sprite : '0;
  assign vga.disp_rel_x  = vga.disp_valid ? rd_entry.rel_x  : '0;
  assign vga.disp_rel_y  = vga.disp_valid ? rd_entry.rel_y  : '0;
endmodule

// File: tb/tb_sprite_line_filler.sv
// Directed bench for sprite_line_filler with a behavioural object table.
module tb_sprite_line_filler;
  logic       clk = 1'b0;
  logic       reset;
  logic       line_start;
  logic [9:0] line_y;
  logic       busy, overrun;
  int         checks = 0;
  int         failures = 0;

  logic [11:0] tab_x   [32];
  logic [11:0] tab_y   [32];
  logic [5:0]  tab_spr [32];
  logic        tab_act [32];

  sprite_line_filler_if ifc ();

  sprite_line_filler dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .line_y     (line_y),
    .vga        (ifc),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Object table with one cycle of read latency.
  always @(posedge clk) begin
    ifc.obj_rd_x      <= tab_x[ifc.obj_rd_idx];
    ifc.obj_rd_y      <= tab_y[ifc.obj_rd_idx];
    ifc.obj_rd_sprite <= tab_spr[ifc.obj_rd_idx];
    ifc.obj_rd_active <= tab_act[ifc.obj_rd_idx];
  end

  task automatic clear_table();
    for (int i = 0; i < 32; i++) begin
      tab_x[i] = '0; tab_y[i] = '0; tab_spr[i] = '0; tab_act[i] = 1'b0;
    end
  endtask

  task automatic set_obj(input int i, input int x, input int y, input int spr, input logic act);
    tab_x[i] = 12'(x); tab_y[i] = 12'(y); tab_spr[i] = 6'(spr); tab_act[i] = act;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_idle busy=%b required=0 after %0d cycles", busy, n);
    end
  endtask

  task automatic pulse_line(input int y);
    line_y     = 10'(y);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic do_line(input int y);
    wait_idle();
    pulse_line(y);
  endtask

  task automatic read_px(input int x);
    ifc.disp_x = 10'(x);
    @(negedge clk);
  endtask

  task automatic expect_px(input string name, input int x, input logic v,
                           input int id, input int spr, input int rx, input int ry);
    read_px(x);
    checks++;
    if (ifc.disp_valid !== v || ifc.disp_obj_id !== 5'(id) || ifc.disp_sprite !== 6'(spr) ||
        ifc.disp_rel_x !== 4'(rx) || ifc.disp_rel_y !== 4'(ry)) begin
      failures++;
      $display("FAIL %s x=%0d got v=%b id=%0d spr=%0d rx=%0d ry=%0d required v=%b id=%0d spr=%0d rx=%0d ry=%0d",
               name, x, ifc.disp_valid, ifc.disp_obj_id, ifc.disp_sprite, ifc.disp_rel_x,
               ifc.disp_rel_y, v, id, spr, rx, ry);
    end
  endtask

  task automatic test_reset();
    for (int x = 0; x < 640; x++) begin
      read_px(x);
      checks++;
      if (ifc.disp_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
        failures++;
        $display("FAIL reset_sweep x=%0d got v=%b busy=%b ovr=%b required 0 0 0",
                 x, ifc.disp_valid, busy, overrun);
      end
    end
    expect_px("reset_fields", 5, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_single();
    clear_table();
    set_obj(0, 200, 240, 0, 1'b1);
    do_line(245);
    do_line(245);
    for (int x = 200; x < 216; x++) expect_px("single", x, 1'b1, 0, 0, x - 200, 5);
    expect_px("single_left", 199, 1'b0, 0, 0, 0, 0);
    expect_px("single_right", 216, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_priority();
    clear_table();
    set_obj(0, 100, 50, 3, 1'b1);
    set_obj(1, 100, 50, 7, 1'b1);
    do_line(50);
    do_line(50);
    for (int x = 100; x < 116; x++) expect_px("prio_same", x, 1'b1, 0, 3, x - 100, 0);
    set_obj(1, 108, 50, 7, 1'b1);
    do_line(50);
    do_line(50);
    expect_px("prio_top", 108, 1'b1, 0, 3, 8, 0);
    expect_px("prio_top_end", 115, 1'b1, 0, 3, 15, 0);
    for (int x = 116; x < 124; x++) expect_px("prio_under", x, 1'b1, 1, 7, x - 108, 0);
    expect_px("prio_after", 124, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_clipping();
    clear_table();
    set_obj(3, 630, 300, 9, 1'b1);
    do_line(303);
    do_line(303);
    for (int x = 630; x < 640; x++) expect_px("clip_right", x, 1'b1, 3, 9, x - 630, 3);
    expect_px("clip_offscreen", 640, 1'b0, 0, 0, 0, 0);
    clear_table();
    set_obj(0, 4090, 4090, 1, 1'b1);
    set_obj(1, 4090, 0, 2, 1'b1);
    do_line(0);
    do_line(0);
    for (int x = 0; x < 12; x++) expect_px("no_wrap", x, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic test_overrun();
    clear_table();
    set_obj(0, 200, 240, 4, 1'b1);
    do_line(245);
    repeat (499) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL overrun_busy got=%b required=1", busy);
    end
    pulse_line(245);
    checks++;
    if (overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_pulse got=%b required=1", overrun);
    end
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_width got=%b required=0", overrun);
    end
    expect_px("overrun_bg", 200, 1'b0, 0, 0, 0, 0);
    expect_px("overrun_bg2", 210, 1'b0, 0, 0, 0, 0);
    do_line(245);
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clean_swap got=%b required=0", overrun);
    end
    expect_px("overrun_recover", 200, 1'b1, 0, 4, 0, 5);
    expect_px("overrun_recover2", 215, 1'b1, 0, 4, 15, 5);
  endtask

  task automatic test_inactive_and_reset();
    clear_table();
    set_obj(0, 200, 240, 0, 1'b1);
    set_obj(2, 300, 240, 5, 1'b0);
    do_line(245);
    do_line(245);
    expect_px("inactive", 300, 1'b0, 0, 0, 0, 0);
    expect_px("active_other", 200, 1'b1, 0, 0, 0, 5);
    do_line(245);
    repeat (685) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || ifc.disp_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset busy=%b v=%b required 1 1", busy, ifc.disp_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || ifc.disp_valid !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset busy=%b v=%b ovr=%b required 0 0 0", busy, ifc.disp_valid, overrun);
    end
    @(negedge clk);
    reset = 1'b0;
    do_line(245);
    expect_px("post_reset_first", 200, 1'b0, 0, 0, 0, 0);
    do_line(245);
    expect_px("post_reset_second", 200, 1'b1, 0, 0, 0, 5);
  endtask

  initial begin
    clear_table();
    reset      = 1'b1;
    line_start = 1'b0;
    line_y     = '0;
    ifc.disp_x = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_clipping();
    test_overrun();
    test_inactive_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
